posit_encoder_pipe: RTL
=======================

// Module: posit_encoder_pipe
// PURPOSE
//  Final pipeline stage of the posit datapath: packs a normalised (sign, scaled exponent,
//  mantissa+sticky) result back into an n-bit posit word, with round-to-nearest-even
//  and saturation. Exact inverse of the decoder field format. Sits after the
//  accumulate/normalise stage. 2-stage pipeline with valid/ready flow control.
// PARAMETERS
//  n          16                        posit word size
//  es         1                         exponent field size
//  nd         posit_pkg::clog2(n-1)     derived; do not override
//  EXP_WIDTH  nd+es                     scaled-exponent magnitude bits; port carries sign too
//  FRAC_WIDTH n-es-1                    input fraction bits below the implicit 1
// PORTS
//  clk_i       in   1             clock, rising edge
//  rst_ni      in   1             asynchronous reset, active low
//  in_valid_i  in   1             input fields valid
//  in_ready_o  out  1             stage can accept input
//  sign_i      in   1             result sign
//  rg_exp_i    in   EXP_WIDTH+1   signed scaled exponent, k*2^es + e
//  frac_i      in   FRAC_WIDTH    fraction bits, MSB = 2^-1 (implicit 1 not carried)
//  sticky_i    in   1             OR of all discarded lower bits
//  zero_i      in   1             result is exactly zero (overrides fields)
//  nar_i       in   1             result is NaR (overrides zero and fields)
//  out_valid_o out  1             posit_o valid
//  out_ready_i in   1             downstream accepts
//  posit_o     out  n             encoded posit
// BEHAVIOUR
//  - Reset: out_valid_o=0, posit_o=0, both stage valid flags 0. in_ready_o=1 one cycle after
//    release; it is combinational, so it also reads 1 during reset. The pipe clears mid-flight.
//  - Handshake: transfer when valid&&ready. Stage s loads when empty or its successor loads.
//    in_ready_o = !v1 || (!v2 || out_ready_i). Full throughput of 1/cycle.
//    Latency 2 cycles from input handshake to out_valid_o. A bubble in the data does not
//    break throughput.
//  - Output holds its value and valid when out_ready_i=0. Inputs are ignored while in_ready_o=0.
//  - S1 (classify/clamp):
//    - maxexp = (n-2)<<es. If rg_exp_i > maxexp, force maxpos.
//    - If rg_exp_i < -maxexp, force minpos.
//    - Else k = rg_exp_i>>>es, e = rg_exp_i[es-1:0].
//    - Regime: k>=0 gives (k+1) ones then a zero; k<0 gives -k zeros then a one.
//    - Register the flags, the k-derived shift, e, frac, and sticky.
//  - S2 (pack/round):
//    - Form {regime, e, frac}. Right-shift it into n-1 bits.
//    - Keep guard = first dropped bit. Set st = OR(rest dropped bits, sticky).
//    - Round up iff guard && (lsb || st).
//    - A round-up carry into the sign position is clamped to maxpos.
//    - A nonzero value never rounds to 0; the minimum result is minpos.
//    - Negative results: posit_o = two's complement of {0, magnitude}.
//  - Specials: nar_i gives 1<<(n-1); zero_i gives 0. Rounding and sign are skipped for both.
//  - maxpos = {0,{n-1{1}}}, minpos = 1. Negatives are their two's complements.
// STRUCTURE
//  - posit_pkg: clog2, and functions maxexp(n,es), maxpos(n), minpos(n), nar(n).
//  - Sub-module posit_round_pack (combinational S2 core: shift, RNE, clamp, negate).
//    It is reused later by the quire converter.
//  - Shift is done with the existing barrel_shifter in right-shift mode.
// TESTING (n=16, es=1, out_ready_i=1 unless stated)
//  - Fraction values below are FRAC_WIDTH=14 bit vectors.
//  - Case 1: sign=0, rg_exp=0, frac=0 gives 0x4000 after 2 cycles.
//    rg_exp=0, frac=0x2000 (1.5) gives 0x4800. sign=1, rg_exp=0, frac=0 gives 0xC000.
//  - Case 2: rg_exp=0 (12 fraction bits kept). frac=0x0006, sticky=0 is a tie with odd lsb
//    and gives 0x4002. frac=0x0002 is a tie with even lsb and gives 0x4000.
//    frac=0x0002 with sticky=1 gives 0x4001.
//  - Case 3: rg_exp=+29 gives 0x7FFF. rg_exp=-29 gives 0x0001.
//    rg_exp=-28 with sign=1 gives 0xFFFF.
//  - Case 4: nar_i=1 gives 0x8000. zero_i=1 gives 0x0000.
//    nar_i and zero_i both 1 gives 0x8000.
//  - Case 5: stream 8 back-to-back words with out_ready_i low for 3 cycles mid-stream.
//    Required: no loss, no duplication, order kept, in_ready_o falls only when both
//    stages are full.
//  - Case 6: assert rst_ni low with 2 words in flight.
//    Required: out_valid_o=0 immediately, and no stale word appears after release.

Source files
------------

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared classification type and constant helpers for the posit datapath
package posit_pkg;

    // Result class decided in the clamp stage; everything except CLS_NORMAL
    // bypasses rounding in the pack stage.
    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_NAR,
        CLS_MAXPOS,
        CLS_MINPOS
    } posit_cls_e;

    // Ceiling log2, used to size the regime run-length field.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Largest scaled exponent that still encodes without saturating.
    function automatic int maxexp(input int n, input int es);
        return (n - 2) << es;
    endfunction

    function automatic logic [31:0] maxpos(input int n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] minpos(input int n);
        return (n > 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] nar(input int n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - logarithmic barrel shifter with selectable direction and fill bit
//
// Ports:
//   data_i   WIDTH  word to shift
//   shamt_i  SHW    shift distance
//   left_i   1      1 = shift left, 0 = shift right
//   fill_i   1      value shifted into the vacated positions
//   data_o   WIDTH  shifted word
module barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             left_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] cur;

    // One conditional power-of-two stage per shift-amount bit.
    always_comb begin
        cur = data_i;
        for (int s = 0; s < SHW; s++) begin
            if (shamt_i[s]) begin
                if (left_i) begin
                    cur = (cur << (1 << s)) | ({WIDTH{fill_i}} & ~(ONES << (1 << s)));
                end else begin
                    cur = (cur >> (1 << s)) | ({WIDTH{fill_i}} & ~(ONES >> (1 << s)));
                end
            end
        end
        data_o = cur;
    end

endmodule

// File: rtl/posit_round_pack.sv
// rtl/posit_round_pack.sv - combinational posit pack core: regime shift, RNE, clamp, negate
//
// Ports:
//   cls_i     3        result class (posit_cls_e)
//   sign_i    1        result sign
//   k_pos_i   1        regime k >= 0
//   shamt_i   nd       regime run extension: k for k>=0, -k-1 for k<0
//   exp_i     es       exponent field
//   frac_i    n-es-1   fraction below the implicit 1
//   sticky_i  1        OR of bits already discarded upstream
//   posit_o   n        encoded posit
module posit_round_pack
    import posit_pkg::*;
#(
    parameter int n  = 16,
    parameter int es = 1,
    parameter int nd = clog2(n - 1)
) (
    input  logic [2:0]        cls_i,
    input  logic              sign_i,
    input  logic              k_pos_i,
    input  logic [nd-1:0]     shamt_i,
    input  logic [es-1:0]     exp_i,
    input  logic [n-es-2:0]   frac_i,
    input  logic              sticky_i,
    output logic [n-1:0]      posit_o
);

    localparam int FW = n - es - 1;
    localparam int MW = n - 1;
    // Head + fields, plus MW zero bits so no shifted-out bit is lost before sticky.
    localparam int W  = 2 + es + FW + MW;

    localparam logic [MW-1:0] MAXMAG = MW'(maxpos(n));
    localparam logic [MW-1:0] MINMAG = MW'(minpos(n));
    localparam logic [n-1:0]  NAR    = n'(nar(n));

    logic [W-1:0]  unshifted;
    logic [W-1:0]  shifted;
    logic [MW-1:0] trunc;
    logic [MW-1:0] mag;
    logic [MW:0]   sum;
    logic          guard;
    logic          rest;
    logic          round_up;

    // Regime head is "10" for k>=0 and "01" for k<0; shifting right by shamt
    // with the run bit as fill extends the run to its full length.
    assign unshifted = {k_pos_i, !k_pos_i, exp_i, frac_i, {MW{1'b0}}};

    barrel_shifter #(
        .WIDTH(W),
        .SHW  (nd)
    ) u_shift (
        .data_i (unshifted),
        .shamt_i(shamt_i),
        .left_i (1'b0),
        .fill_i (k_pos_i),
        .data_o (shifted)
    );

    assign trunc    = shifted[W-1 -: MW];
    assign guard    = shifted[W-1-MW];
    assign rest     = |shifted[W-2-MW:0] | sticky_i;
    assign round_up = guard & (trunc[0] | rest);
    assign sum      = {1'b0, trunc} + {{MW{1'b0}}, round_up};

    always_comb begin
        mag = sum[MW-1:0];
        if (sum[MW]) begin
            mag = MAXMAG;
        end else if (mag == '0) begin
            mag = MINMAG;
        end
        if (cls_i == CLS_MAXPOS) mag = MAXMAG;
        if (cls_i == CLS_MINPOS) mag = MINMAG;

        posit_o = sign_i ? -{1'b0, mag} : {1'b0, mag};
        if (cls_i == CLS_ZERO) posit_o = '0;
        if (cls_i == CLS_NAR)  posit_o = NAR;
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// rtl/posit_encoder_pipe.sv - two-stage posit encoder with saturation, RNE and valid/ready flow
//
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   in_valid_i / in_ready_o      input handshake
//   sign_i                       result sign
//   rg_exp_i   EXP_WIDTH+1       signed scaled exponent k*2^es + e
//   frac_i     FRAC_WIDTH        fraction, MSB weight 2^-1
//   sticky_i                     OR of discarded lower bits
//   zero_i, nar_i                specials (nar wins)
//   out_valid_o / out_ready_i    output handshake
//   posit_o    n                 encoded posit
module posit_encoder_pipe
    import posit_pkg::*;
#(
    parameter int  n          = 16,
    parameter int  es         = 1,
    localparam int nd         = clog2(n - 1),
    localparam int EXP_WIDTH  = nd + es,
    localparam int FRAC_WIDTH = n - es - 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  sign_i,
    input  logic [EXP_WIDTH:0]    rg_exp_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    input  logic                  sticky_i,
    input  logic                  zero_i,
    input  logic                  nar_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [n-1:0]          posit_o
);

    localparam logic signed [EXP_WIDTH:0] MAXEXP = (EXP_WIDTH + 1)'(maxexp(n, es));
    localparam logic signed [EXP_WIDTH:0] MINEXP = -MAXEXP;

    logic                  load1;
    logic                  load2;
    logic                  v1_q;
    logic                  v2_q;
    posit_cls_e            cls_d;
    posit_cls_e            cls_q;
    logic [nd-1:0]         shamt_d;
    logic [nd-1:0]         shamt_q;
    logic                  sign_q;
    logic                  k_pos_q;
    logic [es-1:0]         exp_q;
    logic [FRAC_WIDTH-1:0] frac_q;
    logic                  sticky_q;
    logic [n-1:0]          packed_w;
    logic [n-1:0]          posit_q;

    assign load2      = !v2_q || out_ready_i;
    assign load1      = !v1_q || load2;
    assign in_ready_o = load1;

    always_comb begin
        cls_d = CLS_NORMAL;
        if (nar_i) begin
            cls_d = CLS_NAR;
        end else if (zero_i) begin
            cls_d = CLS_ZERO;
        end else if ($signed(rg_exp_i) > MAXEXP) begin
            cls_d = CLS_MAXPOS;
        end else if ($signed(rg_exp_i) < MINEXP) begin
            cls_d = CLS_MINPOS;
        end
    end

    // k = rg_exp >>> es is just the upper bits; for negative k the zero run
    // beyond the head is -k-1, which is ~k in two's complement.
    assign shamt_d = rg_exp_i[EXP_WIDTH] ? ~rg_exp_i[EXP_WIDTH-1:es] : rg_exp_i[EXP_WIDTH-1:es];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            cls_q    <= CLS_ZERO;
            sign_q   <= 1'b0;
            k_pos_q  <= 1'b0;
            shamt_q  <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            sticky_q <= 1'b0;
        end else if (load1) begin
            v1_q     <= in_valid_i;
            cls_q    <= cls_d;
            sign_q   <= sign_i;
            k_pos_q  <= !rg_exp_i[EXP_WIDTH];
            shamt_q  <= shamt_d;
            exp_q    <= rg_exp_i[es-1:0];
            frac_q   <= frac_i;
            sticky_q <= sticky_i;
        end
    end

    posit_round_pack #(
        .n (n),
        .es(es),
        .nd(nd)
    ) u_round_pack (
        .cls_i   (cls_q),
        .sign_i  (sign_q),
        .k_pos_i (k_pos_q),
        .shamt_i (shamt_q),
        .exp_i   (exp_q),
        .frac_i  (frac_q),
        .sticky_i(sticky_q),
        .posit_o (packed_w)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q    <= 1'b0;
            posit_q <= '0;
        end else if (load2) begin
            v2_q <= v1_q;
            if (v1_q) posit_q <= packed_w;
        end
    end

    assign out_valid_o = v2_q;
    assign posit_o     = posit_q;

endmodule
